// File: rtl/mc_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, then one sign-fix cycle.
module mc_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned ACC_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic             r_neg_lo;
  logic             r_neg_hi;
  logic             r_div0;
  logic [WIDTH-1:0] r_opnd;
  logic [ACC_W-1:0] r_acc;

  logic             w_accept;
  logic             w_step;
  logic             w_fix;
  logic             w_mtx;

  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  logic [WIDTH:0]   w_mul_sum;
  logic [ACC_W-1:0] w_mul_nxt;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic [ACC_W-1:0] w_div_nxt;

  logic [ACC_W-1:0] w_prod;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CALC;
      S_CALC:  if (r_cnt == CNT_W'(WIDTH - 1)) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Per-state control strobes
  always_comb begin
    w_accept = 1'b0;
    w_step   = 1'b0;
    w_fix    = 1'b0;
    w_mtx    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = start;
        w_mtx    = 1'b1;
      end
      S_CALC:  w_step = 1'b1;
      S_FIX:   w_fix  = 1'b1;
      default: ;
    endcase
  end

  // Operand magnitudes; op[0] selects the signed variants
  assign w_a_neg  = op[0] & a[WIDTH-1];
  assign w_b_neg  = op[0] & b[WIDTH-1];
  assign w_b_zero = (b == '0);
  assign w_a_mag  = w_a_neg ? (~a + WIDTH'(1)) : a;
  assign w_b_mag  = w_b_neg ? (~b + WIDTH'(1)) : b;

  // Multiply step: {P, multiplier} shifts right, P gains the multiplicand when lsb set
  assign w_mul_sum = {1'b0, r_acc[ACC_W-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide step: {R, Q} shifts left, keep the subtraction only if it does not borrow
  assign w_rem_sh  = r_acc[ACC_W-1:WIDTH-1];
  assign w_diff    = w_rem_sh - {1'b0, r_opnd};
  assign w_div_nxt = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                   : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};

  // Sign correction; a zero divisor leaves R = |a| so restoring its sign yields a
  assign w_prod   = r_neg_lo ? (~r_acc + ACC_W'(1)) : r_acc;
  assign w_q_fix  = r_div0 ? {WIDTH{1'b1}}
                  : (r_neg_lo ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0]);
  assign w_r_fix  = r_neg_hi ? (~r_acc[ACC_W-1:WIDTH] + WIDTH'(1)) : r_acc[ACC_W-1:WIDTH];
  assign w_res_hi = r_is_div ? w_r_fix : w_prod[ACC_W-1:WIDTH];
  assign w_res_lo = r_is_div ? w_q_fix : w_prod[WIDTH-1:0];

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_div0   <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_is_div <= op[1];
      r_neg_lo <= op[1] ? ((w_a_neg ^ w_b_neg) & ~w_b_zero) : (w_a_neg ^ w_b_neg);
      r_neg_hi <= op[1] ? w_a_neg : (w_a_neg ^ w_b_neg);
      r_div0   <= op[1] & w_b_zero;
      r_opnd   <= op[1] ? w_b_mag : w_a_mag;
      r_acc    <= {WIDTH'(0), (op[1] ? w_a_mag : w_b_mag)};
    end else if (w_step) begin
      r_cnt    <= r_cnt + CNT_W'(1);
      r_acc    <= r_is_div ? w_div_nxt : w_mul_nxt;
    end
  end

  // Architectural HI/LO: operation results in FIX, MTHI/MTLO only while idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else if (w_fix) begin
      hi <= w_res_hi;
      lo <= w_res_lo;
    end else if (w_mtx) begin
      if (wr_hi) hi <= wdata;
      if (wr_lo) lo <= wdata;
    end
  end

  // Handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (w_next != S_IDLE);
      done <= w_fix;
    end
  end

endmodule

// File: doc/mc_muldiv.md
# mc_muldiv

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the multi-cycle MIPS core. It adds MULT/MULTU/DIV/DIVU and MTHI/MTLO support, which the current datapath lacks. The control FSM launches an operation with a one-cycle `start` and stalls on `busy`. Results are read back through `hi`/`lo` (MFHI/MFLO) into the register-file write-data mux.

## Interface
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits. Must be even and ≥ 4.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  launches an operation. Accepted only when `busy`=0.
- `op`  in  2  operation, sampled with `start`:
  - 00 MULTU
  - 01 MULT
  - 10 DIVU
  - 11 DIV
- `a`  in  WIDTH  multiplicand / dividend (rs value). Sampled with `start`.
- `b`  in  WIDTH  multiplier / divisor (rt value). Sampled with `start`.
- `wr_hi`  in  1  MTHI write strobe.
- `wr_lo`  in  1  MTLO write strobe.
- `wdata`  in  WIDTH  data for `wr_hi`/`wr_lo`.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse when HI/LO have just been updated by an operation.
- `hi`  out  WIDTH  HI register (product upper half / remainder).
- `lo`  out  WIDTH  LO register (product lower half / quotient).

## Operation
- States: IDLE, CALC, FIX.
- IDLE, `start`=1:
  - Latch `op`.
  - Latch operand magnitudes: the absolute value for signed ops, raw for unsigned.
  - Latch result-sign flags.
  - Clear the iteration counter (width clog2(WIDTH)+1) and go to CALC.
- CALC: one iteration per cycle, exactly WIDTH cycles, then go to FIX.
  - Multiply: shift-add on the 2·WIDTH accumulator {P, multiplier}.
  - Divide: restoring shift-subtract on the 2·WIDTH remainder/quotient register.
- FIX (one cycle):
  - Apply sign correction.
  - Write `hi`/`lo`, pulse `done`, return to IDLE.
- Signed multiply: full 2·WIDTH two's-complement product. Negate when the sign flags differ.
- Signed divide:
  - Quotient truncates toward zero and is negative iff the operand signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero (`b`=0, either divide op):
  - Full latency is kept.
  - Result is `hi`=`a` and `lo`=all ones, for both DIV and DIVU.
- DIV overflow (`a`=most negative, `b`=−1): `lo`=most negative, `hi`=0. No flag.
- `wr_hi`/`wr_lo` in IDLE:
  - Load `hi`/`lo` from `wdata` at the edge; both may be asserted together.
  - While `busy`=1 they are ignored.
- `start` together with `wr_hi`/`wr_lo` in IDLE: the write takes effect at that edge, and the operation result overwrites it in FIX.
- `start` while `busy`=1 is ignored; `op`/`a`/`b` are not resampled.
- `hi`/`lo` hold their previous values throughout CALC. There are no partial results.

## Timing
- Reset, asynchronous, while `rst`=0:
  - Outputs: `busy`=0, `done`=0, `hi`=0, `lo`=0.
  - State IDLE; counter and internal registers 0.
- Reset mid-operation aborts the operation. No `done` is pulsed after release.
- `start` sampled at edge E0:
  - `busy`=1 from E0 through E(WIDTH+1).
  - CALC runs on edges E1..E(WIDTH).
  - FIX is at E(WIDTH+1): `hi`/`lo` update and `busy` falls.
  - `done` is high for exactly the cycle after E(WIDTH+1).
- Latency is WIDTH+1 cycles from the accepting edge to valid `hi`/`lo` (33 for WIDTH=32). It does not depend on data or op.
- Back-to-back: a new `start` is accepted on the edge where `done` is high (state is IDLE). Throughput is one op per WIDTH+2 cycles.
- `busy`, `done`, `hi`, `lo` are registered outputs with no combinational path from inputs.
- MTHI/MTLO write latency is one edge.

## Test plan
- Reset:
  - Assert `rst`=0 mid-CALC of a MULTU: `busy`, `done`, `hi`, `lo` go to 0 immediately, without waiting for a clock edge.
  - After release, no `done` pulse appears within 40 cycles.
- WIDTH=32 MULT:
  - `a`=0xFFFFFFFD (−3), `b`=7: `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
  - `done` is high 33 cycles after the start edge.
  - Repeat as MULTU: `hi`=0x00000006, `lo`=0xFFFFFFEB.
- WIDTH=32 DIV:
  - −7/2 gives `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - 7/−2 gives `lo`=0xFFFFFFFD, `hi`=1.
  - 0x80000000/0xFFFFFFFF gives `lo`=0x80000000, `hi`=0.
- Divide by zero: DIVU `a`=0x1234, `b`=0 gives `hi`=0x1234, `lo`=0xFFFFFFFF with normal latency.
- Handshake:
  - Pulse `start` with new operands and `wr_hi` mid-operation: both are ignored, and the original result lands.
  - A second `start` in the `done` cycle is accepted and completes 33 cycles later.
  - `wr_hi`+`wr_lo` in IDLE with `wdata`=0xA5A5A5A5 loads both registers at the next edge.
- WIDTH=8 parameter sweep:
  - Random signed and unsigned mul/div, 1000 vectors, checked against a reference model.
  - `done` arrives 9 cycles after `start`.
